// File: rtl/aer_window_buffer.sv
// aer_window_buffer: captures a window of AER spike events and streams it to the SNN core.
module aer_window_buffer #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spike_valid,
    input  logic [DATA_W-1:0] aer_data,
    input  logic              clear_buffers,
    input  logic              start_processing,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [ADDR_W:0]   event_count,
    output logic              overflow,
    output logic [DROP_W-1:0] dropped_count,
    output logic              busy,
    output logic              drain_done
);
    typedef enum logic [1:0] {CAPTURE, DRAIN, DONE} state_t;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              full, load, fin;
    logic [DROP_W-1:0] drop_inc;
    always_comb begin
        full     = event_count == FULL;
        load     = state == DRAIN && rd_ptr != event_count && (!out_valid || out_ready);
        fin      = state == DRAIN && out_valid && out_ready && out_last;
        drop_inc = &dropped_count ? dropped_count : dropped_count + 1'b1;
    end
    always_ff @(posedge clk)
        if (rst_n && state == CAPTURE && spike_valid && !clear_buffers && !full)
            mem[wr_ptr] <= aer_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= CAPTURE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            event_count   <= '0;
            overflow      <= 1'b0;
            dropped_count <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            drain_done    <= 1'b0;
        end else if (clear_buffers) begin
            state         <= CAPTURE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            event_count   <= '0;
            overflow      <= 1'b0;
            dropped_count <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            drain_done    <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            case (state)
                CAPTURE: begin
                    if (spike_valid && !full) begin
                        wr_ptr      <= wr_ptr + 1'b1;
                        event_count <= event_count + 1'b1;
                    end else if (spike_valid) begin
                        overflow      <= 1'b1;
                        dropped_count <= drop_inc;
                    end
                    // a spike arriving with the start pulse is part of this window
                    if (start_processing && (event_count != '0 || spike_valid)) begin
                        state  <= DRAIN;
                        rd_ptr <= '0;
                        busy   <= 1'b1;
                    end else if (start_processing) begin
                        state      <= DONE;
                        drain_done <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (spike_valid)
                        dropped_count <= drop_inc;
                    if (load) begin
                        out_valid <= 1'b1;
                        out_data  <= mem[rd_ptr[ADDR_W-1:0]];
                        out_last  <= rd_ptr == event_count - 1'b1;
                        rd_ptr    <= rd_ptr + 1'b1;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                    if (fin) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        drain_done  <= 1'b1;
                        wr_ptr      <= '0;
                        rd_ptr      <= '0;
                        event_count <= '0;
                    end
                end
                default: begin
                    if (spike_valid)
                        dropped_count <= drop_inc;
                    state <= CAPTURE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aer_window_buffer.sv
// tb_aer_window_buffer: directed vector table plus hand sequences for overflow, clear and reset corners.
module tb_aer_window_buffer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        spike_valid = 1'b0, clear_buffers = 1'b0, start_processing = 1'b0, out_ready = 1'b0;
    logic [19:0] aer_data = '0;
    logic        out_valid, out_last, overflow, busy, drain_done;
    logic [19:0] out_data;
    logic [8:0]  event_count;
    logic [7:0]  dropped_count;
    int          n_chk = 0, n_fail = 0;

    aer_window_buffer dut (
        .clk(clk), .rst_n(rst_n), .spike_valid(spike_valid), .aer_data(aer_data),
        .clear_buffers(clear_buffers), .start_processing(start_processing),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .event_count(event_count), .overflow(overflow), .dropped_count(dropped_count),
        .busy(busy), .drain_done(drain_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [19:0] d;
        logic        clr, st, rdy;
        logic        ev;
        logic [19:0] ed;
        logic        el;
        logic [8:0]  ec;
        logic        eb, edn;
    } vec_t;
    vec_t tbl[30];

    function automatic vec_t mk(logic sv, logic [19:0] d, logic clr, logic st, logic rdy,
                                logic ev, logic [19:0] ed, logic el, logic [8:0] ec, logic eb, logic edn);
        vec_t v;
        v.sv = sv; v.d = d; v.clr = clr; v.st = st; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.el = el; v.ec = ec; v.eb = eb; v.edn = edn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic [19:0] d, input logic clr, input logic st, input logic rdy);
        spike_valid = sv; aer_data = d; clear_buffers = clr; start_processing = st; out_ready = rdy;
    endtask

    int beats, guard, hs;

    initial begin
        // basic 3-event window, backpressured 4-event window, empty drain, clear in capture
        tbl[0]  = mk(1, 20'h10001, 0, 0, 1, 0, 0,        0, 1, 0, 0);
        tbl[1]  = mk(1, 20'h20002, 0, 0, 1, 0, 0,        0, 2, 0, 0);
        tbl[2]  = mk(1, 20'h3000A, 0, 0, 1, 0, 0,        0, 3, 0, 0);
        tbl[3]  = mk(0, 0,         0, 1, 1, 0, 0,        0, 3, 1, 0);
        tbl[4]  = mk(0, 0,         0, 0, 1, 1, 20'h10001, 0, 3, 1, 0);
        tbl[5]  = mk(0, 0,         0, 0, 1, 1, 20'h20002, 0, 3, 1, 0);
        tbl[6]  = mk(0, 0,         0, 0, 1, 1, 20'h3000A, 1, 3, 1, 0);
        tbl[7]  = mk(0, 0,         0, 0, 1, 0, 0,        0, 0, 0, 1);
        tbl[8]  = mk(0, 0,         0, 0, 1, 0, 0,        0, 0, 0, 0);
        tbl[9]  = mk(1, 20'hA0001, 0, 0, 0, 0, 0,        0, 1, 0, 0);
        tbl[10] = mk(1, 20'hA0002, 0, 0, 0, 0, 0,        0, 2, 0, 0);
        tbl[11] = mk(1, 20'hA0003, 0, 0, 0, 0, 0,        0, 3, 0, 0);
        tbl[12] = mk(1, 20'hA0004, 0, 0, 0, 0, 0,        0, 4, 0, 0);
        tbl[13] = mk(0, 0,         0, 1, 1, 0, 0,        0, 4, 1, 0);
        tbl[14] = mk(0, 0,         0, 0, 1, 1, 20'hA0001, 0, 4, 1, 0);
        tbl[15] = mk(0, 0,         0, 0, 0, 1, 20'hA0001, 0, 4, 1, 0);
        tbl[16] = mk(0, 0,         0, 0, 0, 1, 20'hA0001, 0, 4, 1, 0);
        tbl[17] = mk(0, 0,         0, 0, 1, 1, 20'hA0002, 0, 4, 1, 0);
        tbl[18] = mk(0, 0,         0, 0, 0, 1, 20'hA0002, 0, 4, 1, 0);
        tbl[19] = mk(0, 0,         0, 0, 0, 1, 20'hA0002, 0, 4, 1, 0);
        tbl[20] = mk(0, 0,         0, 0, 1, 1, 20'hA0003, 0, 4, 1, 0);
        tbl[21] = mk(0, 0,         0, 0, 1, 1, 20'hA0004, 1, 4, 1, 0);
        tbl[22] = mk(0, 0,         0, 0, 0, 1, 20'hA0004, 1, 4, 1, 0);
        tbl[23] = mk(0, 0,         0, 0, 1, 0, 0,        0, 0, 0, 1);
        tbl[24] = mk(0, 0,         0, 0, 1, 0, 0,        0, 0, 0, 0);
        tbl[25] = mk(0, 0,         0, 1, 1, 0, 0,        0, 0, 0, 1);
        tbl[26] = mk(0, 0,         0, 0, 1, 0, 0,        0, 0, 0, 0);
        tbl[27] = mk(1, 20'h00005, 0, 0, 1, 0, 0,        0, 1, 0, 0);
        tbl[28] = mk(0, 0,         1, 0, 1, 0, 0,        0, 0, 0, 0);
        tbl[29] = mk(1, 20'h00006, 1, 0, 1, 0, 0,        0, 0, 0, 0);

        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_count", event_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", dropped_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", drain_done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].sv, tbl[i].d, tbl[i].clr, tbl[i].st, tbl[i].rdy);
            step();
            chk($sformatf("v%0d_valid", i), out_valid, tbl[i].ev);
            if (tbl[i].ev) chk($sformatf("v%0d_data", i), out_data, tbl[i].ed);
            chk($sformatf("v%0d_last", i), out_last, tbl[i].el);
            chk($sformatf("v%0d_count", i), event_count, tbl[i].ec);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].eb);
            chk($sformatf("v%0d_done", i), drain_done, tbl[i].edn);
        end
        chk("post_tbl_drop", dropped_count, 0);

        // overflow: 260 events into 256 entries
        for (int i = 0; i < 260; i++) begin
            drive(1, 20'(i), 0, 0, 1);
            step();
        end
        chk("ovf_count", event_count, 256);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", dropped_count, 4);
        drive(0, 0, 0, 1, 1);
        step();
        drive(0, 0, 0, 0, 1);
        chk("ovf_busy", busy, 1);
        step();
        beats = 0;
        guard = 0;
        while (beats < 256 && guard < 600) begin
            if (out_valid) begin
                chk($sformatf("ovf_beat%0d_data", beats), out_data, beats);
                chk($sformatf("ovf_beat%0d_last", beats), out_last, beats == 255);
                beats++;
            end
            step();
            guard++;
        end
        chk("ovf_beats", beats, 256);
        chk("ovf_done", drain_done, 1);
        chk("ovf_valid_after", out_valid, 0);
        chk("ovf_count_after", event_count, 0);
        chk("ovf_flag_kept", overflow, 1);
        chk("ovf_drop_kept", dropped_count, 4);
        step();
        chk("ovf_done_once", drain_done, 0);

        // clear mid-drain after 2 of 5 beats accepted
        for (int i = 0; i < 5; i++) begin
            drive(1, 20'hC0000 + 20'(i), 0, 0, 1);
            step();
        end
        chk("clr_count5", event_count, 5);
        drive(0, 0, 0, 1, 1);
        step();
        drive(0, 0, 0, 0, 1);
        step();
        chk("clr_b0", out_data, 20'hC0000);
        step();
        chk("clr_b1", out_data, 20'hC0001);
        step();
        chk("clr_b2", out_data, 20'hC0002);
        drive(0, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 1);
        chk("clr_valid", out_valid, 0);
        chk("clr_count", event_count, 0);
        chk("clr_ovf", overflow, 0);
        chk("clr_drop", dropped_count, 0);
        chk("clr_busy", busy, 0);
        hs = 0;
        for (int i = 0; i < 3; i++) begin
            hs += drain_done;
            hs += out_valid;
            step();
        end
        chk("clr_no_done", hs, 0);
        drive(1, 20'hBEEF1, 0, 1, 1);
        step();
        drive(0, 0, 0, 0, 1);
        step();
        chk("clr_new_valid", out_valid, 1);
        chk("clr_new_data", out_data, 20'hBEEF1);
        chk("clr_new_last", out_last, 1);
        step();
        chk("clr_new_done", drain_done, 1);
        step();

        // spikes during drain, then asynchronous reset mid-drain
        for (int i = 0; i < 4; i++) begin
            drive(1, 20'hD0000 + 20'(i), 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 1, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        chk("rd_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 20'hFFFFF, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        chk("rd_drop3", dropped_count, 3);
        chk("rd_count", event_count, 4);
        chk("rd_ovf", overflow, 0);
        chk("rd_hold", out_data, 20'hD0000);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_data", out_data, 0);
        chk("ar_last", out_last, 0);
        chk("ar_count", event_count, 0);
        chk("ar_drop", dropped_count, 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", drain_done, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("ar_idle_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule
